// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment driver for a clock display. It scans
// HH.MM or MM.SS from a per-frame snapshot and adds a blinking point and alarm flash.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] hour_out1,
  input  logic [3:0] hour_out0,
  input  logic [3:0] minute_out1,
  input  logic [3:0] minute_out0,
  input  logic [3:0] second_out1,
  input  logic [3:0] second_out0,
  input  logic       Alarm,
  input  logic       mode,
  input  logic       display_enable,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RC_W = $clog2(REFRESH_DIV);
  localparam int BC_W = $clog2(BLINK_DIV);

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
    logic       mode;
    logic       alarm;
  } snap_t;

  logic [RC_W-1:0] rc;
  logic [1:0]      idx;
  logic [BC_W-1:0] bc;
  logic            blink_phase;
  logic            mode_s1, mode_s2, alarm_s1, alarm_s2;
  snap_t           snap;
  logic [3:0]      digit;
  logic            rc_wrap, frame_end, dark;

  assign rc_wrap   = (rc == RC_W'(REFRESH_DIV - 1));
  assign frame_end = rc_wrap && (idx == 2'd3);
  assign dark      = !display_enable || (snap.alarm && !blink_phase);

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  always_comb begin
    // NOTE: default assignment first so no path leaves digit unassigned (no latch).
    digit = 4'd0;
    case (idx)
      2'd3:    digit = snap.mode ? snap.m1 : {2'b00, snap.h1};
      2'd2:    digit = snap.mode ? snap.m0 : snap.h0;
      2'd1:    digit = snap.mode ? snap.s1 : snap.m1;
      default: digit = snap.mode ? snap.s0 : snap.m0;
    endcase
  end

  // Scan/blink timebase, input synchronizers and the once-per-frame snapshot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      rc          <= '0;
      idx         <= 2'd0;
      bc          <= '0;
      blink_phase <= 1'b0;
      mode_s1     <= 1'b0;
      mode_s2     <= 1'b0;
      alarm_s1    <= 1'b0;
      alarm_s2    <= 1'b0;
      snap        <= '0;
    end else begin
      mode_s1  <= mode;
      mode_s2  <= mode_s1;
      alarm_s1 <= Alarm;
      alarm_s2 <= alarm_s1;

      if (rc_wrap) begin
        rc  <= '0;
        idx <= idx + 2'd1;
      end else begin
        rc <= rc + RC_W'(1);
      end

      if (bc == BC_W'(BLINK_DIV - 1)) begin
        bc          <= '0;
        blink_phase <= !blink_phase;
      end else begin
        bc <= bc + BC_W'(1);
      end

      if (frame_end) begin
        snap <= '{h1: hour_out1, h0: hour_out0, m1: minute_out1, m0: minute_out0,
                  s1: second_out1, s0: second_out0, mode: mode_s2, alarm: alarm_s2};
      end
    end
  end

  // Registered drive; a single-hot anode pattern keeps at most one digit lit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an  <= 4'hF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (dark) begin
      an  <= 4'hF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= decode(digit);
      dp  <= !((idx == 2'd2) && blink_phase);
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: directed literal scenarios plus
// randomized stimulus against an edge-count based reference model.
module tb_seven_seg_scanner;

  localparam int R = 4;
  localparam int B = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] hour_out1 = '0;
  logic [3:0] hour_out0 = '0, minute_out1 = '0, minute_out0 = '0;
  logic [3:0] second_out1 = '0, second_out0 = '0;
  logic       Alarm = 1'b0, mode = 1'b0, display_enable = 1'b1;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int tests = 0;
  int fails = 0;

  seven_seg_scanner #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clock(clock), .reset(reset),
    .hour_out1(hour_out1), .hour_out0(hour_out0),
    .minute_out1(minute_out1), .minute_out0(minute_out0),
    .second_out1(second_out1), .second_out0(second_out0),
    .Alarm(Alarm), .mode(mode), .display_enable(display_enable),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state is derived from k, the number of edges since reset release.
  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  int         k = 0;
  logic [3:0] sn_h1 = '0, sn_h0 = '0, sn_m1 = '0, sn_m0 = '0, sn_s1 = '0, sn_s0 = '0;
  logic       sn_mode = 1'b0, sn_alarm = 1'b0;
  logic       mode_hist [4];
  logic       alarm_hist [4];
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_dp = 1'b1;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      k        <= 0;
      sn_h1    <= '0; sn_h0 <= '0; sn_m1 <= '0; sn_m0 <= '0; sn_s1 <= '0; sn_s0 <= '0;
      sn_mode  <= 1'b0;
      sn_alarm <= 1'b0;
      exp_an   <= 4'hF;
      exp_seg  <= 7'h7F;
      exp_dp   <= 1'b1;
    end else begin : model_step
      int         pos, e;
      logic       phase;
      logic [3:0] d;
      logic [1:0] hs;
      pos   = (k / R) % 4;
      phase = ((k / B) % 2) == 1;
      e     = k + 1;
      if (sn_mode)
        d = (pos == 3) ? sn_m1 : (pos == 2) ? sn_m0 : (pos == 1) ? sn_s1 : sn_s0;
      else
        d = (pos == 3) ? sn_h1 : (pos == 2) ? sn_h0 : (pos == 1) ? sn_m1 : sn_m0;
      if (!display_enable || (sn_alarm && !phase)) begin
        exp_an  <= 4'hF;
        exp_seg <= 7'h7F;
        exp_dp  <= 1'b1;
      end else begin
        exp_an  <= 4'hF ^ 4'(1 << pos);
        exp_seg <= seg_tbl[d];
        exp_dp  <= !(pos == 2 && phase);
      end
      k <= e;
      hs = 2'(e % 4);
      mode_hist[hs]  <= mode;
      alarm_hist[hs] <= Alarm;
      // A frame ends every 4*R edges; mode/Alarm seen there are two edges old.
      if (e % (4 * R) == 0) begin
        sn_h1    <= {2'b00, hour_out1};
        sn_h0    <= hour_out0;
        sn_m1    <= minute_out1;
        sn_m0    <= minute_out0;
        sn_s1    <= second_out1;
        sn_s0    <= second_out0;
        sn_mode  <= mode_hist[2'((e - 2) % 4)];
        sn_alarm <= alarm_hist[2'((e - 2) % 4)];
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clock) begin
    if (cmp_en) begin
      check("an", 32'(an), 32'(exp_an));
      check("seg", 32'(seg), 32'(exp_seg));
      check("dp", 32'(dp), 32'(exp_dp));
      check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    end
  end

  int n = 0;

  task automatic adv_to(input int target);
    while (n < target) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic lit(input string name, input logic [3:0] a, input logic [6:0] s, input logic d);
    check({name, "_an"}, 32'(an), 32'(a));
    check({name, "_seg"}, 32'(seg), 32'(s));
    check({name, "_dp"}, 32'(dp), 32'(d));
  endtask

  task automatic release_reset();
    reset = 1'b1;
    n = 0;
  endtask

  // Called just after a negedge: drop reset mid-cycle, confirm outputs go dark at once.
  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1 lit("async_rst", 4'hF, 7'h7F, 1'b1);
    @(negedge clock);
    @(negedge clock);
    release_reset();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    cmp_en = 1'b1;
    lit("in_reset", 4'hF, 7'h7F, 1'b1);

    release_reset();
    adv_to(1);  lit("scan0", 4'b1110, 7'h40, 1'b1);
    adv_to(4);  lit("scan0_end", 4'b1110, 7'h40, 1'b1);
    adv_to(5);  lit("scan1", 4'b1101, 7'h40, 1'b1);
    adv_to(9);  lit("scan2", 4'b1011, 7'h40, 1'b1);
    adv_to(13); lit("scan3", 4'b0111, 7'h40, 1'b1);
    adv_to(17); lit("scan_wrap", 4'b1110, 7'h40, 1'b1);

    hour_out1 = 2'd1; hour_out0 = 4'd2; minute_out1 = 4'd3; minute_out0 = 4'd4;
    second_out1 = 4'd5; second_out0 = 4'd6;
    adv_to(29); lit("pre_snap", 4'b0111, 7'h40, 1'b1);
    adv_to(33); lit("hm_idx0", 4'b1110, 7'h19, 1'b1);
    adv_to(37); lit("hm_idx1", 4'b1101, 7'h30, 1'b1);
    adv_to(41); lit("hm_idx2", 4'b1011, 7'h24, 1'b1);
    adv_to(45); lit("hm_idx3", 4'b0111, 7'h79, 1'b1);

    mode = 1'b1;
    adv_to(49); lit("ms_idx0", 4'b1110, 7'h02, 1'b1);
    adv_to(53); lit("ms_idx1", 4'b1101, 7'h12, 1'b1);
    adv_to(57); lit("ms_idx2_dp", 4'b1011, 7'h19, 1'b0);
    adv_to(61); lit("ms_idx3", 4'b0111, 7'h30, 1'b1);

    minute_out0 = 4'd12; mode = 1'b0;
    adv_to(65); lit("blank_digit", 4'b1110, 7'h7F, 1'b1);
    adv_to(66); hour_out0 = 4'd7;
    adv_to(73); lit("old_h0", 4'b1011, 7'h24, 1'b1);
    adv_to(89); lit("new_h0", 4'b1011, 7'h78, 1'b0);

    Alarm = 1'b1;
    adv_to(97);  lit("alarm_dark0", 4'hF, 7'h7F, 1'b1);
    adv_to(112); lit("alarm_dark1", 4'hF, 7'h7F, 1'b1);
    adv_to(113); lit("alarm_lit", 4'b1110, 7'h7F, 1'b1);
    adv_to(121); lit("alarm_dp", 4'b1011, 7'h78, 1'b0);
    adv_to(129); lit("alarm_dark2", 4'hF, 7'h7F, 1'b1);
    Alarm = 1'b0;
    adv_to(145); lit("alarm_off0", 4'b1110, 7'h7F, 1'b1);
    adv_to(161); lit("alarm_off1", 4'b1110, 7'h7F, 1'b1);

    display_enable = 1'b0;
    hour_out1 = '0; hour_out0 = '0; minute_out1 = '0; minute_out0 = '0;
    second_out1 = '0; second_out0 = '0;
    adv_to(162); lit("disabled", 4'hF, 7'h7F, 1'b1);
    adv_to(163);
    pulse_reset();
    display_enable = 1'b1;
    adv_to(1); lit("post_rst0", 4'b1110, 7'h40, 1'b1);
    adv_to(5); lit("post_rst1", 4'b1101, 7'h40, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 39) == 0) Alarm = ~Alarm;
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      if (display_enable ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 9) == 0))
        display_enable = ~display_enable;
      if ($urandom_range(0, 19) == 0) hour_out1 = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0) hour_out0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) minute_out1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) minute_out0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) second_out1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) second_out0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) pulse_reset();
    end

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles each digit is lit (1 ms at 100 MHz); SHALL be >= 2.
REQ-002 Parameter BLINK_DIV, default 50000000, clock cycles per blink phase (0.5 s at 100 MHz); SHALL be >= 2.
REQ-003 clock  in  1  100 MHz system clock; the only clock in the block.
REQ-004 reset  in  1  asynchronous, active-low reset; low forces the reset state immediately, independent of clock.
REQ-005 hour_out1  in  2  clock hour tens digit, 0..2.
REQ-006 hour_out0, minute_out1, minute_out0, second_out1, second_out0  in  4 each  clock time digits.
REQ-007 Alarm  in  1  alarm-active flag from the alarm clock.
REQ-008 mode  in  1  selects the view: 0 = HH.MM, 1 = MM.SS.
REQ-009 display_enable  in  1  high = display on; low = all digits dark.
REQ-010 an  out  4  digit anode enables, active-low; an[3] is the leftmost digit.
REQ-011 seg  out  7  segment enables {g,f,e,d,c,b,a}, active-low.
REQ-012 dp  out  1  decimal point, active-low.

Function
REQ-013 Refresh counter rc SHALL count 0..REFRESH_DIV-1 and then wrap; on the wrap edge, digit index idx (2 bits) SHALL advance mod 4.
REQ-014 Snapshot: on the edge where rc wraps with idx==3, the block SHALL latch all six digit inputs, plus synchronized mode and Alarm, into a snapshot register.
REQ-015 Display content SHALL come only from the snapshot; input changes mid-scan SHALL NOT appear until the next snapshot.
REQ-016 Alarm and mode SHALL each pass through a two-flop synchronizer before use.
REQ-017 Digit map for mode=0 SHALL be idx3..idx0 = hour_out1, hour_out0, minute_out1, minute_out0.
REQ-018 Digit map for mode=1 SHALL be idx3..idx0 = minute_out1, minute_out0, second_out1, second_out0.
REQ-019 Decode (hex, active-low) SHALL be 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; any value 10..15 SHALL decode to blank 7F.
REQ-020 Blink counter SHALL count 0..BLINK_DIV-1; blink_phase SHALL toggle on each wrap.
REQ-021 an, seg and dp SHALL be registered and SHALL reflect idx, snapshot and blink_phase one clock cycle after those change.
REQ-022 Normal drive: an = ~(1<<idx); seg = decode(selected digit); dp = 0 only when idx==2 and blink_phase==1, otherwise dp = 1.
REQ-023 Alarm flash: while snapshot Alarm==1 and blink_phase==0, outputs SHALL be an=1111, seg=7F, dp=1.
REQ-024 While display_enable==0, outputs SHALL be an=1111, seg=7F, dp=1; counters and the snapshot SHALL keep running.
REQ-025 At most one bit of an SHALL be low in any cycle.

Reset
REQ-026 While reset==0, the block SHALL hold an=1111, seg=7F, dp=1, rc=0, idx=0, blink counter=0, blink_phase=0, all snapshot and synchronizer bits 0.
REQ-027 On the first edge after reset release, outputs SHALL become an=1110, seg=40.
REQ-028 Reset asserted mid-scan SHALL return all outputs to their reset values without waiting for a clock edge.

Verification (REFRESH_DIV=4, BLINK_DIV=16)
REQ-029 Reset release, all inputs 0: an=1110 seg=40 for 4 cycles, then an=1101, then 1011, then 0111, then repeats.
REQ-030 Inputs hour=1,2, min=3,4, sec=5,6, mode=0, after one snapshot: an 0111/seg 79, 1011/24, 1101/30, 1110/19.
REQ-031 Same inputs with mode=1, after a snapshot: digits show 3,4,5,6 (seg 30, 19, 12, 02).
REQ-032 minute_out0=12 applied: digit idx0 shows seg=7F; hour_out0 changed mid-scan: change appears only after the idx3->0 wrap.
REQ-033 Alarm=1: an=1111 for 16 cycles, then digits for 16 cycles with dp=0 only while an=1011; Alarm=0 restores steady display.
REQ-034 display_enable=0, then reset pulsed low mid-scan: outputs stay dark; after release, scenario REQ-029 repeats.
